// File: rtl/if_id.sv
// if_id: IF/ID pipeline register (PC, PC+2, instruction) with load enable; IF_ID_FLUSH_EN adds a Flush bubble input
module if_id #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             RegWrite,
    input  logic [WIDTH-1:0] IPCP2,
    input  logic [WIDTH-1:0] IPC,
    input  logic [WIDTH-1:0] IIR,
`ifdef IF_ID_FLUSH_EN
    input  logic             Flush,
`endif
    output logic [WIDTH-1:0] OPCP2,
    output logic [WIDTH-1:0] OPC,
    output logic [WIDTH-1:0] OIR
);
    logic             flush;
    logic [WIDTH-1:0] pcp2_q, pc_q, ir_q;
    logic [WIDTH-1:0] pcp2_d, pc_d, ir_d;
`ifdef IF_ID_FLUSH_EN
    assign flush = Flush;
`else
    assign flush = 1'b0;
`endif
    // next state: flush inserts a zero bubble, else load when enabled, else hold
    always_comb begin
        pcp2_d = flush ? '0 : RegWrite ? IPCP2 : pcp2_q;
        pc_d   = flush ? '0 : RegWrite ? IPC   : pc_q;
        ir_d   = flush ? '0 : RegWrite ? IIR   : ir_q;
    end
    // state registers, cleared asynchronously by active-low Reset
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            pcp2_q <= '0;
            pc_q   <= '0;
            ir_q   <= '0;
        end else begin
            pcp2_q <= pcp2_d;
            pc_q   <= pc_d;
            ir_q   <= ir_d;
        end
    end
    assign OPCP2 = pcp2_q;
    assign OPC   = pc_q;
    assign OIR   = ir_q;
endmodule

// File: tb/tb_if_id.sv
// tb_if_id: directed self-checking bench for the IF/ID pipeline register
module tb_if_id;
    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        RegWrite = 1'b0;
    logic [15:0] IPCP2 = '0, IPC = '0, IIR = '0;
    logic [15:0] OPCP2, OPC, OIR;
`ifdef IF_ID_FLUSH_EN
    logic        Flush = 1'b0;
`endif
    int n_checks = 0;
    int n_fail = 0;

    if_id #(.WIDTH(16)) dut (
        .CLK(CLK), .Reset(Reset), .RegWrite(RegWrite),
        .IPCP2(IPCP2), .IPC(IPC), .IIR(IIR),
`ifdef IF_ID_FLUSH_EN
        .Flush(Flush),
`endif
        .OPCP2(OPCP2), .OPC(OPC), .OIR(OIR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [15:0] e_pcp2, input logic [15:0] e_pc, input logic [15:0] e_ir);
        chk({tag, ".OPCP2"}, OPCP2, e_pcp2);
        chk({tag, ".OPC"}, OPC, e_pc);
        chk({tag, ".OIR"}, OIR, e_ir);
    endtask

    task automatic edge_tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RegWrite = 1'b1; IPCP2 = 16'h1234; IPC = 16'h5678; IIR = 16'h9ABC;
        edge_tick();
        chk3("reset_low", 16'h0000, 16'h0000, 16'h0000);
        @(negedge CLK);
        Reset = 1'b1;
        #1;
        chk3("release_no_load", 16'h0000, 16'h0000, 16'h0000);
        edge_tick();
        chk3("first_load", 16'h1234, 16'h5678, 16'h9ABC);
        @(negedge CLK);
        RegWrite = 1'b0; IPCP2 = 16'h1111; IPC = 16'hFFFF; IIR = 16'hAAAA;
        edge_tick();
        chk3("stall_hold", 16'h1234, 16'h5678, 16'h9ABC);
        edge_tick();
        chk3("stall_hold2", 16'h1234, 16'h5678, 16'h9ABC);
        @(negedge CLK);
        RegWrite = 1'b1;
        #1;
        chk3("no_comb_path", 16'h1234, 16'h5678, 16'h9ABC);
        edge_tick();
        chk3("load2", 16'h1111, 16'hFFFF, 16'hAAAA);
        @(negedge CLK);
        IPCP2 = 16'h0F0F; IPC = 16'h8001; IIR = 16'h7FFE;
        edge_tick();
        chk3("load3", 16'h0F0F, 16'h8001, 16'h7FFE);
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        chk3("async_clear", 16'h0000, 16'h0000, 16'h0000);
        edge_tick();
        edge_tick();
        chk3("reset_holds", 16'h0000, 16'h0000, 16'h0000);
        @(negedge CLK);
        RegWrite = 1'b0; IPCP2 = 16'hC0DE; IPC = 16'hBEEF; IIR = 16'hFACE;
        #2;
        Reset = 1'b1;
        edge_tick();
        chk3("release_stalled", 16'h0000, 16'h0000, 16'h0000);
        @(negedge CLK);
        RegWrite = 1'b1;
        edge_tick();
        chk3("load_after_release", 16'hC0DE, 16'hBEEF, 16'hFACE);
`ifdef IF_ID_FLUSH_EN
        @(negedge CLK);
        RegWrite = 1'b0; Flush = 1'b1;
        edge_tick();
        chk3("flush_stalled", 16'h0000, 16'h0000, 16'h0000);
        @(negedge CLK);
        RegWrite = 1'b1; Flush = 1'b0;
        edge_tick();
        chk3("reload", 16'hC0DE, 16'hBEEF, 16'hFACE);
        @(negedge CLK);
        Flush = 1'b1;
        edge_tick();
        chk3("flush_over_load", 16'h0000, 16'h0000, 16'h0000);
        Flush = 1'b0;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
